rx_fifo_interface: RTL and testbench

Parametrised receive buffer between the UART receiver shift logic and the host read port. Replaces the single-word buffer/flag pair with a DEPTH-entry first-word-fall-through FIFO. Adds occupancy count, almost-full and full indication, and a sticky overrun flag. The receiver side pushes one word per SetFlag strobe; the host side pops one word per ClearFlag acknowledge.

---
 rtl/rx_fifo_pkg.sv | 20 ++
 rtl/rx_fifo_mem.sv | 44 ++++
 rtl/rx_fifo_interface.sv | 134 +++++++++++++
 tb/tb_rx_fifo_interface.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// rx_fifo_pkg
// Shared definitions for the UART receive FIFO.
//   RX_WORD_SIZE_DEF : default data word width
//   RX_DEPTH_DEF     : default FIFO depth (power of two)
//   rx_status_t      : status bits as seen by the host register block
// ---------------------------------------------------------------------------
package rx_fifo_pkg;

  localparam int RX_WORD_SIZE_DEF = 8;
  localparam int RX_DEPTH_DEF     = 4;

  typedef struct packed {
    logic flag;
    logic full;
    logic almost_full;
    logic overrun;
  } rx_status_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// ---------------------------------------------------------------------------
// rx_fifo_mem
// DEPTH x WIDTH storage array for the receive FIFO.
// The write port is synchronous. The read port is asynchronous, so the head
// word falls straight through to the output. An active-low synchronous reset
// clears every entry, which makes the read data 0 after reset.
// Ports:
//   Clock   : rising-edge clock
//   ResetN  : synchronous active-low clear of all entries
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : word to store (may include the frame-error tag bit)
//   rd_addr : read index
//   rd_data : entry at rd_addr (combinational)
// ---------------------------------------------------------------------------
module rx_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/rx_fifo_interface.sv
// ---------------------------------------------------------------------------
// rx_fifo_interface
// First-word-fall-through receive FIFO between the UART receiver and the
// host read port. The receiver pushes one word per SetFlag strobe, the host
// pops one word per ClearFlag acknowledge. Occupancy is tracked in a
// separate counter; empty/full are derived from it only.
//
// Optional feature (macro RX_FIFO_FRAME_ERR_EN): a frame-error tag bit is
// stored alongside each word (FrameErrIn / FrameErrOut).
//
// Ports:
//   Clock        : rising-edge clock
//   ResetN       : synchronous active-low reset
//   DataIn       : word from receiver
//   SetFlag      : push strobe
//   ClearFlag    : pop acknowledge (ignored while empty)
//   ClearOverrun : clears the sticky Overrun flag (a new drop wins)
//   DataOut      : head-of-FIFO word, valid while Flag=1
//   Flag         : FIFO not empty
//   Full         : Count == DEPTH
//   AlmostFull   : Count >= ALMOST_FULL_LEVEL
//   Count        : occupancy 0..DEPTH
//   Overrun      : sticky, a push was dropped because the FIFO was full
//   FrameErrIn   : (optional) error tag sampled with each push
//   FrameErrOut  : (optional) error tag of the head entry
// ---------------------------------------------------------------------------
module rx_fifo_interface
  import rx_fifo_pkg::*;
#(
  parameter int WORD_SIZE         = RX_WORD_SIZE_DEF,
  parameter int DEPTH             = RX_DEPTH_DEF,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  input  logic [WORD_SIZE-1:0]     DataIn,
  input  logic                     SetFlag,
  input  logic                     ClearFlag,
  input  logic                     ClearOverrun,
  output logic [WORD_SIZE-1:0]     DataOut,
  output logic                     Flag,
  output logic                     Full,
  output logic                     AlmostFull,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overrun
`ifdef RX_FIFO_FRAME_ERR_EN
  ,
  input  logic                     FrameErrIn,
  output logic                     FrameErrOut
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef RX_FIFO_FRAME_ERR_EN
  localparam int MEM_W = WORD_SIZE + 1;
`else
  localparam int MEM_W = WORD_SIZE;
`endif

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  rx_status_t       status_reg;
  rx_status_t       status_next;

  logic             pop_ok;
  logic             push_ok;
  logic             drop;
  logic [MEM_W-1:0] wr_data;
  logic [MEM_W-1:0] rd_data;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when the host acknowledges at the same time. In the
  // empty case the pop is rejected, so the push simply makes Count 1.
  assign pop_ok  = ClearFlag && (count_reg != '0);
  assign push_ok = SetFlag && ((count_reg != CNT_W'(DEPTH)) || pop_ok);
  assign drop    = SetFlag && !push_ok;

  assign count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);

  // Status flags are registered from the next count so the outputs come
  // straight from flops.
  always_comb begin
    status_next             = '0;
    status_next.flag        = (count_next != '0);
    status_next.full        = (count_next == CNT_W'(DEPTH));
    status_next.almost_full = (count_next >= CNT_W'(ALMOST_FULL_LEVEL));
    status_next.overrun     = drop || (status_reg.overrun && !ClearOverrun);
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      status_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg  <= count_next;
      status_reg <= status_next;
    end
  end

`ifdef RX_FIFO_FRAME_ERR_EN
  assign wr_data     = {FrameErrIn, DataIn};
  assign FrameErrOut = rd_data[WORD_SIZE];
`else
  assign wr_data = DataIn;
`endif

  rx_fifo_mem #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  assign DataOut    = rd_data[WORD_SIZE-1:0];
  assign Flag       = status_reg.flag;
  assign Full       = status_reg.full;
  assign AlmostFull = status_reg.almost_full;
  assign Overrun    = status_reg.overrun;
  assign Count      = count_reg;

endmodule

// File: tb/tb_rx_fifo_interface.sv
// ---------------------------------------------------------------------------
// tb_rx_fifo_interface
// Directed self-checking bench for rx_fifo_interface (WORD_SIZE=8, DEPTH=4,
// ALMOST_FULL_LEVEL=3). Inputs change 1 ns after the rising edge and are
// checked mid-cycle.
// ---------------------------------------------------------------------------
module tb_rx_fifo_interface;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic [7:0] DataIn;
  logic       SetFlag;
  logic       ClearFlag;
  logic       ClearOverrun;
  logic [7:0] DataOut;
  logic       Flag;
  logic       Full;
  logic       AlmostFull;
  logic [2:0] Count;
  logic       Overrun;

  int n_cmp = 0;
  int n_err = 0;

  rx_fifo_interface #(
    .WORD_SIZE         (8),
    .DEPTH             (4),
    .ALMOST_FULL_LEVEL (3)
  ) dut (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .DataIn       (DataIn),
    .SetFlag      (SetFlag),
    .ClearFlag    (ClearFlag),
    .ClearOverrun (ClearOverrun),
    .DataOut      (DataOut),
    .Flag         (Flag),
    .Full         (Full),
    .AlmostFull   (AlmostFull),
    .Count        (Count),
    .Overrun      (Overrun)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs, then return to idle.
  task automatic cyc(input logic set, input logic [7:0] din, input logic clr, input logic clro);
    SetFlag      = set;
    DataIn       = din;
    ClearFlag    = clr;
    ClearOverrun = clro;
    @(posedge Clock);
    #1;
    SetFlag      = 1'b0;
    ClearFlag    = 1'b0;
    ClearOverrun = 1'b0;
    DataIn       = 8'h00;
    #3;
  endtask

  initial begin
    ResetN = 1'b0; SetFlag = 1'b0; ClearFlag = 1'b0; ClearOverrun = 1'b0; DataIn = 8'h00;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    ResetN = 1'b1;
    check("rst_count", Count, 0);
    check("rst_flag", Flag, 0);
    check("rst_full", Full, 0);
    check("rst_af", AlmostFull, 0);
    check("rst_ovr", Overrun, 0);
    check("rst_dout", DataOut, 0);
    $display("reset: Count=%0d Flag=%0b DataOut=%0h", Count, Flag, DataOut);

    // single push / pop
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    check("push1_flag", Flag, 1);
    check("push1_dout", DataOut, 8'hAA);
    check("push1_count", Count, 1);
    $display("push AA: Count=%0d DataOut=%0h", Count, DataOut);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("pop1_flag", Flag, 0);
    check("pop1_count", Count, 0);
    $display("pop: Count=%0d Flag=%0b", Count, Flag);

    // fill, almost-full/full thresholds
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    check("fill1_af", AlmostFull, 0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0);
    check("fill2_af", AlmostFull, 0);
    check("fill2_count", Count, 2);
    cyc(1'b1, 8'h03, 1'b0, 1'b0);
    check("fill3_af", AlmostFull, 1);
    check("fill3_full", Full, 0);
    cyc(1'b1, 8'h04, 1'b0, 1'b0);
    check("fill4_full", Full, 1);
    check("fill4_count", Count, 4);
    check("fill4_dout", DataOut, 8'h01);
    $display("fill 01..04: Count=%0d Full=%0b AlmostFull=%0b", Count, Full, AlmostFull);

    // overflow push is dropped
    cyc(1'b1, 8'h05, 1'b0, 1'b0);
    check("ovf_ovr", Overrun, 1);
    check("ovf_count", Count, 4);
    check("ovf_dout", DataOut, 8'h01);
    $display("push 05 on full: Overrun=%0b Count=%0d", Overrun, Count);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_d2", DataOut, 8'h02);
    check("drain_full", Full, 0);
    check("drain_c3", Count, 3);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_d3", DataOut, 8'h03);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_d4", DataOut, 8'h04);
    check("drain_c1", Count, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_flag", Flag, 0);
    check("drain_c0", Count, 0);
    check("drain_ovr_sticky", Overrun, 1);
    $display("drained 01..04: Count=%0d Overrun=%0b", Count, Overrun);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("clro_ovr", Overrun, 0);
    $display("clear overrun: Overrun=%0b", Overrun);

    // full + simultaneous push and pop
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    check("full2_count", Count, 4);
    cyc(1'b1, 8'h10, 1'b1, 1'b0);
    check("fullpp_ovr", Overrun, 0);
    check("fullpp_count", Count, 4);
    check("fullpp_full", Full, 1);
    check("fullpp_dout", DataOut, 8'h22);
    $display("full push 10 + pop: Count=%0d Overrun=%0b DataOut=%0h", Count, Overrun, DataOut);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("fullpp_d23", DataOut, 8'h23);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("fullpp_d24", DataOut, 8'h24);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("fullpp_d10", DataOut, 8'h10);
    check("fullpp_c1", Count, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("fullpp_empty", Flag, 0);

    // empty + simultaneous push and pop
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    check("emptypp_count", Count, 1);
    check("emptypp_dout", DataOut, 8'h33);
    check("emptypp_flag", Flag, 1);
    $display("empty push 33 + pop: Count=%0d DataOut=%0h", Count, DataOut);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("underflow_count", Count, 0);
    check("underflow_flag", Flag, 0);
    $display("pop while empty: Count=%0d", Count);

    // set beats clear on Overrun
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h45, 1'b0, 1'b0);
    check("ovr2_set", Overrun, 1);
    cyc(1'b1, 8'h46, 1'b0, 1'b1);
    check("ovr2_setwins", Overrun, 1);
    check("ovr2_count", Count, 4);
    check("ovr2_dout", DataOut, 8'h41);
    $display("set+clear overrun: Overrun=%0b", Overrun);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovr2_clr", Overrun, 0);
    $display("clear overrun alone: Overrun=%0b", Overrun);

    // reset mid-operation with three words buffered and Overrun set
    cyc(1'b1, 8'h47, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("prerst_count", Count, 3);
    check("prerst_ovr", Overrun, 1);
    ResetN = 1'b0;
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    ResetN = 1'b1;
    check("midrst_count", Count, 0);
    check("midrst_flag", Flag, 0);
    check("midrst_dout", DataOut, 0);
    check("midrst_ovr", Overrun, 0);
    check("midrst_full", Full, 0);
    check("midrst_af", AlmostFull, 0);
    $display("mid reset: Count=%0d Flag=%0b DataOut=%0h Overrun=%0b", Count, Flag, DataOut, Overrun);

    // pointer wrap: 3*DEPTH streaming push+pop cycles
    cyc(1'b1, 8'h80, 1'b0, 1'b0);
    check("wrap_first", DataOut, 8'h80);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      check("wrap_dout", DataOut, 32'(8'h80 + i));
      check("wrap_count", Count, 1);
      $display("wrap %0d: DataOut=%0h Count=%0d", i, DataOut, Count);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_end_flag", Flag, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
